// File: rtl/de_exe_stage_pkg.sv
// Shared RV32 pipeline definitions: bubble encoding, DE->EXE FSM states,
// opcode constants and the EXE-stage register bundle.
package de_exe_stage_pkg;

  localparam logic [31:0] NOP_ENC = 32'h00000013;  // addi x0,x0,0

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        valid;
  } exe_regs_t;

  // Bubbles carry pc=0 so downstream hazard compares see an empty slot.
  function automatic exe_regs_t bubble_regs(input logic [31:0] nop);
    exe_regs_t b;
    b       = '0;
    b.instr = nop;
    return b;
  endfunction

endpackage

// File: rtl/de_exe_stage_operand_fwd_mux.sv
// Per-operand 2:1 select between register-file data and a forwarded value.
module operand_fwd_mux #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] fwd,
  input  logic [W-1:0] rf,
  output logic [W-1:0] o
);
  assign o = sel ? fwd : rf;
endmodule

// File: rtl/de_exe_stage.sv
// DE->EXE pipeline register with operand forwarding, load-use bubble
// insertion (bounded by MAX_STALL) and branch/jump squash.
module de_exe_stage
  import de_exe_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_ENC,
  parameter int          MAX_STALL = 2,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_de,
  input  logic [31:0]      pc_de,
  input  logic [31:0]      rs1_data_de,
  input  logic [31:0]      rs2_data_de,
  input  logic [31:0]      imm_de,
  input  logic             hazard_a,
  input  logic             hazard_b,
  input  logic [31:0]      data_a_mgr,
  input  logic [31:0]      data_b_mgr,
  input  logic             stall,
  input  logic             flush,
  output logic             hold_de,
  output logic [31:0]      instr_exe,
  output logic [31:0]      pc_exe,
  output logic [31:0]      imm_exe,
  output logic [31:0]      op_a_exe,
  output logic [31:0]      op_b_exe,
  output logic             valid_exe,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_err
);

  localparam int NUM_OPS = 2;
  localparam int BW      = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  logic [NUM_OPS-1:0]       w_sel;
  logic [NUM_OPS-1:0][31:0] w_fwd, w_rf, w_op;

  assign w_sel = {hazard_b, hazard_a};
  assign w_fwd = {data_b_mgr, data_a_mgr};
  assign w_rf  = {rs2_data_de, rs1_data_de};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    operand_fwd_mux #(.W(32)) u_mux (
      .sel (w_sel[g]),
      .fwd (w_fwd[g]),
      .rf  (w_rf[g]),
      .o   (w_op[g])
    );
  end

  state_e          r_state, w_nxt_state;
  logic [BW-1:0]   r_bcnt, w_nxt_bcnt;
  logic            w_bubble, w_hold, w_cnt_inc, w_set_err;
  exe_regs_t       r_exe, w_exe_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic            r_stall_err;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_bcnt  = r_bcnt;
    w_bubble    = 1'b0;
    w_hold      = 1'b0;
    w_cnt_inc   = 1'b0;
    w_set_err   = 1'b0;
    if (flush) begin
      w_bubble    = 1'b1;
      w_nxt_state = RUN;
      w_nxt_bcnt  = '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (stall) begin
            w_bubble    = 1'b1;
            w_hold      = 1'b1;
            w_cnt_inc   = 1'b1;
            w_nxt_bcnt  = BW'(1);
            w_nxt_state = BUBBLE;
          end
        end
        BUBBLE: begin
          if (stall && (r_bcnt < BW'(MAX_STALL))) begin
            w_bubble   = 1'b1;
            w_hold     = 1'b1;
            w_cnt_inc  = 1'b1;
            w_nxt_bcnt = r_bcnt + BW'(1);
          end else begin
            // Either the stall released or the bound was hit: issue DE now.
            w_set_err   = stall;
            w_nxt_state = RUN;
            w_nxt_bcnt  = '0;
          end
        end
        default: begin
          w_nxt_state = RUN;
          w_nxt_bcnt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_exe_nxt = bubble_regs(NOP_INSTR);
    if (!w_bubble) begin
      w_exe_nxt.instr = instr_de;
      w_exe_nxt.pc    = pc_de;
      w_exe_nxt.imm   = imm_de;
      w_exe_nxt.op_a  = w_op[0];
      w_exe_nxt.op_b  = w_op[1];
      w_exe_nxt.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_bcnt      <= '0;
      r_exe       <= bubble_regs(NOP_INSTR);
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_bcnt  <= w_nxt_bcnt;
      r_exe   <= w_exe_nxt;
      if (w_cnt_inc && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_set_err)
        r_stall_err <= 1'b1;
    end
  end

  assign hold_de   = w_hold & ~rst;
  assign instr_exe = r_exe.instr;
  assign pc_exe    = r_exe.pc;
  assign imm_exe   = r_exe.imm;
  assign op_a_exe  = r_exe.op_a;
  assign op_b_exe  = r_exe.op_b;
  assign valid_exe = r_exe.valid;
  assign stall_cnt = r_stall_cnt;
  assign stall_err = r_stall_err;

endmodule

// File: tb/tb_de_exe_stage.sv
// Directed bench for de_exe_stage: table-driven capture/forwarding vectors
// plus hand-written stall, flush, saturation and async-reset sequences.
module tb_de_exe_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk, rst;
  logic [31:0] instr_de, pc_de, rs1_data_de, rs2_data_de, imm_de;
  logic        hazard_a, hazard_b;
  logic [31:0] data_a_mgr, data_b_mgr;
  logic        stall, flush, stall2, flush2;

  logic        hold_de, valid_exe, stall_err;
  logic [31:0] instr_exe, pc_exe, imm_exe, op_a_exe, op_b_exe;
  logic [15:0] stall_cnt;

  logic        hold2, valid2, err2;
  logic [31:0] instr2, pc2, imm2, opa2, opb2;
  logic [2:0]  cnt2;

  int total = 0;
  int bad   = 0;

  de_exe_stage dut (
    .clk(clk), .rst(rst), .instr_de(instr_de), .pc_de(pc_de),
    .rs1_data_de(rs1_data_de), .rs2_data_de(rs2_data_de), .imm_de(imm_de),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .data_a_mgr(data_a_mgr), .data_b_mgr(data_b_mgr),
    .stall(stall), .flush(flush), .hold_de(hold_de),
    .instr_exe(instr_exe), .pc_exe(pc_exe), .imm_exe(imm_exe),
    .op_a_exe(op_a_exe), .op_b_exe(op_b_exe), .valid_exe(valid_exe),
    .stall_cnt(stall_cnt), .stall_err(stall_err)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  de_exe_stage #(.MAX_STALL(3), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .instr_de(instr_de), .pc_de(pc_de),
    .rs1_data_de(rs1_data_de), .rs2_data_de(rs2_data_de), .imm_de(imm_de),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .data_a_mgr(data_a_mgr), .data_b_mgr(data_b_mgr),
    .stall(stall2), .flush(flush2), .hold_de(hold2),
    .instr_exe(instr2), .pc_exe(pc2), .imm_exe(imm2),
    .op_a_exe(opa2), .op_b_exe(opb2), .valid_exe(valid2),
    .stall_cnt(cnt2), .stall_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_de(input logic [31:0] i, input logic [31:0] p);
    instr_de = i;
    pc_de    = p;
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, ".instr"}, instr_exe, NOP);
    chk({nm, ".pc"},    pc_exe, 32'h0);
    chk({nm, ".opa"},   op_a_exe, 32'h0);
    chk({nm, ".imm"},   imm_exe, 32'h0);
    chk({nm, ".valid"}, 32'(valid_exe), 32'h0);
  endtask

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2, imm;
    logic        ha, hb;
    logic [31:0] da, db;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h00208133, 32'h4,        32'h11,       32'h22,       32'h0,
                1'b0, 1'b0, 32'h0,        32'h0,        32'h11,       32'h22};
    vecs[1] = '{32'h00500093, 32'h8,        32'h5,        32'h6,        32'h5,
                1'b1, 1'b0, 32'hDEAD0000, 32'h12345678, 32'hDEAD0000, 32'h6};
    vecs[2] = '{32'h40110233, 32'hC,        32'h1,        32'h2,        32'hFFFFF800,
                1'b0, 1'b1, 32'hAAAA,     32'hBEEF0001, 32'h1,        32'hBEEF0001};
    vecs[3] = '{32'h002081B3, 32'h10,       32'h3,        32'h4,        32'h7,
                1'b1, 1'b1, 32'h77,       32'h88,       32'h77,       32'h88};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h0,        32'h80000000,
                1'b0, 1'b0, 32'h5,        32'h6,        32'hFFFFFFFF, 32'h0};

    rst = 1'b1; stall = 1'b1; flush = 1'b0; stall2 = 1'b1; flush2 = 1'b0;
    instr_de = 32'h0; pc_de = 32'h0; rs1_data_de = 32'h0; rs2_data_de = 32'h0;
    imm_de = 32'h0; hazard_a = 1'b0; hazard_b = 1'b0;
    data_a_mgr = 32'h0; data_b_mgr = 32'h0;

    // Reset values, with stall requested to show hold_de is masked.
    #2;
    chk_bubble("rst");
    chk("rst.opb",  op_b_exe, 32'h0);
    chk("rst.cnt",  32'(stall_cnt), 32'h0);
    chk("rst.err",  32'(stall_err), 32'h0);
    chk("rst.hold", 32'(hold_de), 32'h0);
    chk("rst2.instr", instr2, NOP);
    chk("rst2.pc",  pc2, 32'h0);
    chk("rst2.imm", imm2, 32'h0);
    chk("rst2.ops", opa2 | opb2, 32'h0);
    chk("rst2.valid", 32'(valid2), 32'h0);
    chk("rst2.hold", 32'(hold2), 32'h0);
    chk("rst2.cnt", 32'(cnt2), 32'h0);
    chk("rst2.err", 32'(err2), 32'h0);
    edge1();
    chk("rst_edge.instr", instr_exe, NOP);
    rst = 1'b0; stall = 1'b0;

    // Saturation on the 3-bit counter: 3 bubbles + forced issue per 4 cycles.
    for (int i = 0; i < 11; i++) edge1();
    chk("sat.cnt11", 32'(cnt2), 32'h7);
    edge1();
    chk("sat.cnt12", 32'(cnt2), 32'h7);
    chk("sat.err",   32'(err2), 32'h1);
    chk("sat.valid", 32'(valid2), 32'h1);
    stall2 = 1'b0;

    // Table-driven capture and forwarding.
    for (int v = 0; v < 5; v++) begin
      set_de(vecs[v].instr, vecs[v].pc);
      rs1_data_de = vecs[v].rs1; rs2_data_de = vecs[v].rs2; imm_de = vecs[v].imm;
      hazard_a = vecs[v].ha; hazard_b = vecs[v].hb;
      data_a_mgr = vecs[v].da; data_b_mgr = vecs[v].db;
      #1;
      chk($sformatf("v%0d.hold", v), 32'(hold_de), 32'h0);
      edge1();
      chk($sformatf("v%0d.instr", v), instr_exe, vecs[v].instr);
      chk($sformatf("v%0d.pc", v),    pc_exe, vecs[v].pc);
      chk($sformatf("v%0d.imm", v),   imm_exe, vecs[v].imm);
      chk($sformatf("v%0d.opa", v),   op_a_exe, vecs[v].exp_a);
      chk($sformatf("v%0d.opb", v),   op_b_exe, vecs[v].exp_b);
      chk($sformatf("v%0d.valid", v), 32'(valid_exe), 32'h1);
    end

    // Single-cycle stall; forwarded value changes while held.
    set_de(32'h00208133, 32'h20);
    rs1_data_de = 32'h5; rs2_data_de = 32'h7; imm_de = 32'h0;
    hazard_a = 1'b1; hazard_b = 1'b0; data_a_mgr = 32'hDEAD0000;
    stall = 1'b1;
    #1;
    chk("st1.hold", 32'(hold_de), 32'h1);
    edge1();
    chk_bubble("st1.bub");
    chk("st1.cnt", 32'(stall_cnt), 32'h1);
    stall = 1'b0; data_a_mgr = 32'hCAFE0000;
    #1;
    chk("st1.hold_rel", 32'(hold_de), 32'h0);
    edge1();
    chk("st1.instr", instr_exe, 32'h00208133);
    chk("st1.pc",    pc_exe, 32'h20);
    chk("st1.opa",   op_a_exe, 32'hCAFE0000);
    chk("st1.opb",   op_b_exe, 32'h7);
    chk("st1.valid", 32'(valid_exe), 32'h1);

    // Stall held 4 cycles: 2 bubbles, forced issue, then a fresh bubble.
    rst = 1'b1; #1; rst = 1'b0;
    set_de(32'h00C00293, 32'h30);
    stall = 1'b1;
    edge1();
    chk_bubble("st4.b1");
    chk("st4.hold1", 32'(hold_de), 32'h1);
    edge1();
    chk_bubble("st4.b2");
    chk("st4.cnt2", 32'(stall_cnt), 32'h2);
    chk("st4.hold_force", 32'(hold_de), 32'h0);
    edge1();
    chk("st4.instr", instr_exe, 32'h00C00293);
    chk("st4.pc",    pc_exe, 32'h30);
    chk("st4.valid", 32'(valid_exe), 32'h1);
    chk("st4.err",   32'(stall_err), 32'h1);
    chk("st4.cnt",   32'(stall_cnt), 32'h2);
    chk("st4.hold3", 32'(hold_de), 32'h1);
    edge1();
    chk_bubble("st4.b3");
    chk("st4.cnt3", 32'(stall_cnt), 32'h3);
    stall = 1'b0;
    set_de(32'h00100513, 32'h34);
    edge1();
    chk("st4.rel.instr", instr_exe, 32'h00100513);

    // Flush + stall in RUN: bubble, no hold, count unchanged.
    stall = 1'b1; flush = 1'b1;
    #1;
    chk("fl.hold", 32'(hold_de), 32'h0);
    edge1();
    chk_bubble("fl.bub");
    chk("fl.cnt", 32'(stall_cnt), 32'h3);
    flush = 1'b0;
    edge1();
    chk("fl.cnt4", 32'(stall_cnt), 32'h4);
    chk("fl.run_hold", 32'(hold_de), 32'h1);
    // Flush while in BUBBLE.
    flush = 1'b1;
    #1;
    chk("flb.hold", 32'(hold_de), 32'h0);
    edge1();
    chk_bubble("flb.bub");
    chk("flb.cnt", 32'(stall_cnt), 32'h4);
    flush = 1'b0; stall = 1'b0;
    set_de(32'h00200593, 32'h38);
    edge1();
    chk("flb.issue", instr_exe, 32'h00200593);
    chk("flb.err",   32'(stall_err), 32'h1);

    // Async reset while in BUBBLE: outputs clear before the next edge.
    set_de(32'h00300613, 32'h3C);
    stall = 1'b1;
    edge1();
    chk("ar.cnt_pre", 32'(stall_cnt), 32'h5);
    #3 rst = 1'b1;
    #1;
    chk("ar.cnt",  32'(stall_cnt), 32'h0);
    chk("ar.err",  32'(stall_err), 32'h0);
    chk("ar.hold", 32'(hold_de), 32'h0);
    chk_bubble("ar.out");
    set_de(32'h00400693, 32'h40);
    edge1();
    chk("ar.no_issue", instr_exe, NOP);
    rst = 1'b0; stall = 1'b0;
    edge1();
    chk("ar.next.instr", instr_exe, 32'h00400693);
    chk("ar.next.pc",    pc_exe, 32'h40);
    chk("ar.next.valid", 32'(valid_exe), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/de_exe_stage.md
# de_exe_stage

Decode-to-execute pipeline register for the RV32 pipeline. It captures the decoded instruction, PC, immediate and source operands into the EXE stage. It substitutes forwarded operands from the hazard/forwarding manager, inserts bubbles on load-use stalls, and squashes the stage on a taken branch/jump. It sits between the register-file read in DE and the ALU in EXE. It drives `instr_exe`, `pc_exe` and the operand buses that both the ALU and the forwarding manager consume.

## Interface
Parameters:
- `NOP_INSTR`, 32'h00000013: encoding loaded as the bubble (`addi x0,x0,0`).
- `MAX_STALL`, 2: maximum consecutive bubbles before a forced issue.
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `instr_de`  in  32: instruction in DE.
- `pc_de`  in  32: PC of `instr_de`.
- `rs1_data_de`, `rs2_data_de`  in  32: register-file read data.
- `imm_de`  in  32: sign-extended immediate.
- `hazard_a`, `hazard_b`  in  1: forward select for operand A/B.
- `data_a_mgr`, `data_b_mgr`  in  32: forwarded operand values.
- `stall`  in  1: load-use stall request.
- `flush`  in  1: taken branch/jump resolved in EXE.
- `hold_de`  out  1: combinational; fetch and DE registers must hold this cycle.
- `instr_exe`, `pc_exe`, `imm_exe`  out  32: EXE-stage instruction, PC, immediate.
- `op_a_exe`, `op_b_exe`  out  32: EXE-stage operands.
- `valid_exe`  out  1: EXE holds a real instruction.
- `stall_cnt`  out  CNT_W: saturating count of bubble cycles inserted by stalls.
- `stall_err`  out  1: sticky; a forced issue occurred.

## Operation
- Operand select: `op_a_next = hazard_a ? data_a_mgr : rs1_data_de`; `op_b_next = hazard_b ? data_b_mgr : rs2_data_de`.
- Two-state FSM, `RUN` / `BUBBLE`, with a bubble counter `bcnt` (0..MAX_STALL).
- `RUN`, no `stall`, no `flush`: capture DE into EXE with `valid_exe=1`, `hold_de=0`.
- `RUN` with `stall`:
  - `hold_de=1`.
  - EXE loads a bubble: `NOP_INSTR`, `pc_exe=0`, operands 0, `imm_exe=0`, `valid_exe=0`.
  - `bcnt=1`, state goes to `BUBBLE`, `stall_cnt` increments.
- `BUBBLE` with `stall` and `bcnt<MAX_STALL`: another bubble, `hold_de=1`, `bcnt++`, `stall_cnt++`.
- `BUBBLE` with no `stall`: issue the held DE instruction using the current operand select, `hold_de=0`, return to `RUN`.
- `BUBBLE` with `stall` and `bcnt==MAX_STALL`: forced issue as above, `stall_err<=1`, return to `RUN`.
- `flush` in any state has priority over `stall`:
  - EXE loads a bubble, `hold_de=0`, state goes to `RUN`, `bcnt=0`.
  - `stall_cnt` does not increment.
- Bubbles always carry `pc_exe=0`, so downstream hazard comparison treats them as empty.
- `stall_cnt` saturates at all-ones and never wraps. `stall_err` clears only on `rst`.

## Timing
- DE-to-EXE latency is one cycle. All EXE outputs are registered and update on the rising `clk` edge.
- `hold_de` is combinational from `stall`, `flush`, state and `bcnt`. It is valid in the same cycle it is asserted.
- Reset values:
  - `instr_exe=NOP_INSTR`; `pc_exe`, `imm_exe`, `op_a_exe`, `op_b_exe` = 0.
  - `valid_exe=0`, `stall_cnt=0`, `stall_err=0`.
  - State `RUN`, `bcnt=0`; `hold_de=0` while `rst` is high.
- Reset asserted mid-stall: outputs clear immediately (asynchronous). The held DE instruction is not issued.
- `stall` and `flush` in the same cycle: the flush rule applies.
- `hazard_*` and `data_*_mgr` are sampled on the same edge that captures the instruction into EXE.

## Structure
- Shared pipeline package:
  - `NOP_INSTR` constant.
  - FSM state encoding (`RUN=1'b0`, `BUBBLE=1'b1`).
  - RV32 opcode constants (shared with the forwarding manager).
- One natural sub-module, `operand_fwd_mux`: a per-operand 2:1 forward select, instantiated twice.
- Everything else is flat: FSM, EXE registers, counters.

## Test plan
- Reset, then `instr_de=32'h00208133`, `pc_de=4`, no hazards. Next edge: `instr_exe=32'h00208133`, `pc_exe=4`, `valid_exe=1`, operands equal the register-file data.
- `hazard_a=1`, `data_a_mgr=32'hDEAD0000`, `rs1_data_de=5`. Required: `op_a_exe=32'hDEAD0000`; `op_b_exe` still takes `rs2_data_de`.
- `stall` high for one cycle:
  - That cycle: `hold_de=1`.
  - Next edge: EXE is a bubble (`instr_exe=32'h00000013`, `pc_exe=0`, `valid_exe=0`), `stall_cnt=1`.
  - Following edge: the held instruction issues with the forwarded operand.
- `stall` held high for 4 cycles with `MAX_STALL=2`. Required: two bubbles, then a forced issue, `stall_err=1`, `stall_cnt=2`.
- `stall` and `flush` together in `RUN`. Required: bubble, `hold_de=0`, `stall_cnt` unchanged, state `RUN`.
- `rst` pulsed asynchronously while in `BUBBLE`. Required: all outputs return to reset values before the next edge, and the held instruction is never issued.
